// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
// Holds the fetch-queue entry layout and its default depth.
package cpu_types_pkg;

   localparam int unsigned WORD_BITS = 32;

   typedef logic [WORD_BITS-1:0] word_t;

   // One fetched instruction together with the PC+4 it was fetched at.
   typedef struct packed {
      word_t instr;
      word_t pc_plus_4;
   } fetch_entry_t;

   // Default number of entries for the fetch/decode instruction buffer.
   localparam int unsigned FETCH_QUEUE_DEPTH = 4;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry storage for fetch_queue.
// One synchronous write port, one asynchronous read port, contents not reset.
module fetch_queue_mem
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH   = FETCH_QUEUE_DEPTH,
   parameter int unsigned ENTRY_W = $bits(fetch_entry_t),
   parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic               CLK,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [ENTRY_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [ENTRY_W-1:0] rdata
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Write the addressed entry on an accepted store.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Head entry is read combinationally.
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for a zero-latency
// empty-queue bypass from the push side straight to the pop outputs.
module fetch_queue
   import cpu_types_pkg::*;
#(
   parameter int unsigned DEPTH  = FETCH_QUEUE_DEPTH,
   parameter int unsigned WORD_W = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       flush,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [WORD_W-1:0]          push_instr,
   input  logic [WORD_W-1:0]          push_pc_plus_4,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [WORD_W-1:0]          pop_instr,
   output logic [WORD_W-1:0]          pop_pc_plus_4,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH+1);
   localparam int unsigned ENTRY_W = 2 * WORD_W;

   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count_q;
   logic [ENTRY_W-1:0] rd_entry;
   logic [ENTRY_W-1:0] wr_entry;
   logic               empty;
   logic               bypass;
   logic               bypass_take;
   logic               do_write;
   logic               do_read;
   logic [WORD_W-1:0]  head_instr;
   logic [WORD_W-1:0]  head_pc;

   fetch_queue_mem #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W),
      .ADDR_W  (PTR_W)
   ) u_mem (
      .CLK   (CLK),
      .we    (do_write),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // Handshake qualification, bypass selection and NOP masking of the head.
   always_comb begin
      empty      = (count_q == '0);
      push_ready = (count_q != CNT_W'(DEPTH));
      wr_entry   = {push_instr, push_pc_plus_4};
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass     = empty && push_valid && !flush;
`else
      bypass     = 1'b0;
`endif
      // A bypassed entry consumed in the same cycle never touches storage.
      bypass_take = bypass && pop_ready;
      pop_valid   = !empty || bypass;
      do_write    = push_valid && push_ready && !flush && !bypass_take;
      do_read     = pop_valid && pop_ready && !empty && !flush;
      if (bypass) begin
         head_instr = push_instr;
         head_pc    = push_pc_plus_4;
      end else begin
         head_instr = rd_entry[ENTRY_W-1:WORD_W];
         head_pc    = rd_entry[WORD_W-1:0];
      end
      pop_instr     = pop_valid ? head_instr : '0;
      pop_pc_plus_4 = pop_valid ? head_pc    : '0;
      count         = count_q;
   end

   // Pointer and occupancy update; flush clears everything in one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(do_write) - CNT_W'(do_read);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a queue-based model
// checked every cycle, plus literal expectations for the listed scenarios.
module tb_fetch_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = $clog2(DEPTH+1);

   typedef struct {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
   } ent_t;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              flush = 1'b0;
   logic              push_valid = 1'b0;
   logic              push_ready;
   logic [WORD_W-1:0] push_instr = '0;
   logic [WORD_W-1:0] push_pc_plus_4 = '0;
   logic              pop_valid;
   logic              pop_ready = 1'b0;
   logic [WORD_W-1:0] pop_instr;
   logic [WORD_W-1:0] pop_pc_plus_4;
   logic [CNT_W-1:0]  count;

   int checks = 0;
   int errors = 0;

   ent_t q[$];

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .flush          (flush),
      .push_valid     (push_valid),
      .push_ready     (push_ready),
      .push_instr     (push_instr),
      .push_pc_plus_4 (push_pc_plus_4),
      .pop_valid      (pop_valid),
      .pop_ready      (pop_ready),
      .pop_instr      (pop_instr),
      .pop_pc_plus_4  (pop_pc_plus_4),
      .count          (count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit byp_now();
      return BYP && (q.size() == 0) && push_valid && !flush;
   endfunction

   // Model: occupancy is the queue size, head is the front (or the bypassed input).
   always @(negedge CLK) begin
      logic              ev;
      logic [WORD_W-1:0] ei;
      logic [WORD_W-1:0] ep;
      ev = (q.size() != 0) || byp_now();
      ei = '0;
      ep = '0;
      if (q.size() != 0) begin
         ei = q[0].instr;
         ep = q[0].pc;
      end else if (byp_now()) begin
         ei = push_instr;
         ep = push_pc_plus_4;
      end
      chk("m_count",      64'(count),         64'(q.size()));
      chk("m_push_ready", 64'(push_ready),    64'(q.size() < DEPTH));
      chk("m_pop_valid",  64'(pop_valid),     64'(ev));
      chk("m_pop_instr",  64'(pop_instr),     64'(ei));
      chk("m_pop_pc",     64'(pop_pc_plus_4), 64'(ep));
   end

   always @(posedge CLK or posedge RST) begin
      if (RST || flush) begin
         q.delete();
      end else if (byp_now() && pop_ready) begin
         // consumed straight through, queue untouched
      end else begin
         int unsigned n;
         n = q.size();
         if (pop_ready && n != 0) void'(q.pop_front());
         if (push_valid && n < DEPTH) q.push_back('{push_instr, push_pc_plus_4});
      end
   end

   task automatic cyc();
      @(negedge CLK);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic push(input logic [WORD_W-1:0] i, input logic [WORD_W-1:0] p);
      push_valid     = 1'b1;
      push_instr     = i;
      push_pc_plus_4 = p;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      // Reset held for two cycles.
      idle();
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_pop_valid", 64'(pop_valid), 64'd0);
      chk("rst_pop_instr", 64'(pop_instr), 64'd0);
      chk("rst_push_ready", 64'(push_ready), 64'd1);
      @(negedge CLK);
      @(posedge CLK);
      #1 RST = 1'b0;

      // Fill to DEPTH with decode stalled.
      for (int i = 0; i < 4; i++) begin
         push(32'h11111111 * (i + 1), 32'h1000 + 32'(4 * i));
         cyc();
      end
      idle();
      @(negedge CLK);
      chk("full_count", 64'(count), 64'd4);
      chk("full_push_ready", 64'(push_ready), 64'd0);
      @(posedge CLK);
      #1;
      push(32'h55555555, 32'h2000);
      cyc();
      idle();
      @(negedge CLK);
      chk("ovf_count", 64'(count), 64'd4);
      chk("ovf_head", 64'(pop_instr), 64'h11111111);
      @(posedge CLK);
      #1;

      // Drain in order.
      pop_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("drain_instr", 64'(pop_instr), 64'(32'h11111111 * (i + 1)));
         chk("drain_pc", 64'(pop_pc_plus_4), 64'(32'h1000 + 32'(4 * i)));
         @(posedge CLK);
         #1;
      end
      idle();
      @(negedge CLK);
      chk("drained_count", 64'(count), 64'd0);
      chk("drained_valid", 64'(pop_valid), 64'd0);
      @(posedge CLK);
      #1;

      // Pop while empty must not underflow.
      pop_ready = 1'b1;
      cyc();
      idle();
      @(negedge CLK);
      chk("udf_count", 64'(count), 64'd0);
      @(posedge CLK);
      #1;

      // Two entries, then 10 cycles of simultaneous push+pop.
      push(32'h00000010, 32'h3004);
      cyc();
      push(32'h00000020, 32'h3008);
      cyc();
      for (int k = 0; k < 10; k++) begin
         push(32'hAAAA0000 + 32'(k), 32'h4000 + 32'(k));
         pop_ready = 1'b1;
         @(negedge CLK);
         chk("sim_count", 64'(count), 64'd2);
         if (k == 0)      chk("sim_head", 64'(pop_instr), 64'h10);
         else if (k == 1) chk("sim_head", 64'(pop_instr), 64'h20);
         else             chk("sim_head", 64'(pop_instr), 64'(32'hAAAA0000 + 32'(k - 2)));
         @(posedge CLK);
         #1;
      end
      idle();
      @(negedge CLK);
      chk("sim_tail_head", 64'(pop_instr), 64'hAAAA0008);
      @(posedge CLK);
      #1;

      // Flush beats same-cycle push and pop.
      push(32'h0000CCCC, 32'h5000);
      cyc();
      idle();
      @(negedge CLK);
      chk("pre_flush_count", 64'(count), 64'd3);
      @(posedge CLK);
      #1;
      push(32'hDEADBEEF, 32'h6000);
      pop_ready = 1'b1;
      flush     = 1'b1;
      cyc();
      idle();
      @(negedge CLK);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(pop_valid), 64'd0);
      chk("flush_instr", 64'(pop_instr), 64'd0);
      chk("flush_ready", 64'(push_ready), 64'd1);
      @(posedge CLK);
      #1;

      // Empty-queue push with decode ready.
      push(32'h8C220004, 32'h7004);
      pop_ready = 1'b1;
      @(negedge CLK);
      chk("byp_valid", 64'(pop_valid), 64'(BYP));
      chk("byp_instr", 64'(pop_instr), BYP ? 64'h8C220004 : 64'd0);
      chk("byp_count", 64'(count), 64'd0);
      @(posedge CLK);
      #1;
      idle();
      @(negedge CLK);
      chk("byp_next_valid", 64'(pop_valid), BYP ? 64'd0 : 64'd1);
      chk("byp_next_instr", 64'(pop_instr), BYP ? 64'd0 : 64'h8C220004);
      chk("byp_next_count", 64'(count), BYP ? 64'd0 : 64'd1);
      @(posedge CLK);
      #1;
      pop_ready = 1'b1;
      cyc();
      idle();

      // Empty-queue push with decode stalled is stored in both builds.
      push(32'h01234567, 32'h7008);
      cyc();
      idle();
      @(negedge CLK);
      chk("stall_push_count", 64'(count), 64'd1);
      chk("stall_push_instr", 64'(pop_instr), 64'h01234567);
      @(posedge CLK);
      #1;

      // Async reset pulsed between edges with three entries queued.
      push(32'h0000A001, 32'h8000);
      cyc();
      push(32'h0000A002, 32'h8004);
      cyc();
      idle();
      #2 RST = 1'b1;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_valid", 64'(pop_valid), 64'd0);
      chk("arst_instr", 64'(pop_instr), 64'd0);
      chk("arst_pc", 64'(pop_pc_plus_4), 64'd0);
      chk("arst_ready", 64'(push_ready), 64'd1);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      push(32'h0000B001, 32'h9000);
      cyc();
      idle();
      @(negedge CLK);
      chk("post_rst_count", 64'(count), 64'd1);
      chk("post_rst_instr", 64'(pop_instr), 64'h0000B001);
      @(posedge CLK);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
